// File: rtl/bs_pkg.sv
// Shared types and constants for the bitstream loader and the bitstream agent interface.
package bs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        WRITE,
        DONE,
        ERR
    } bs_loader_state_t;

    localparam int BS_CNT_WIDTH  = 16;
    localparam int BS_ADDR_WIDTH = 10;
    localparam int BS_GPIO_WIDTH = 8;

endpackage

// File: rtl/bs_loader_timeout.sv
// Idle-cycle watchdog for the loader: counts enabled cycles and flags the cycle that reaches TIMEOUT.
module bs_loader_timeout
    import bs_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [BS_CNT_WIDTH-1:0] LP_LAST = BS_CNT_WIDTH'(TIMEOUT - 1);

    logic [BS_CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != '1)) begin
            r_cnt <= r_cnt + BS_CNT_WIDTH'(1);
        end
    end

    // Fires in the idle cycle whose increment brings the count up to TIMEOUT.
    assign expired = enable && (r_cnt == LP_LAST);

endmodule

// File: rtl/bs_loader.sv
// Serial configuration-bit loader: one bit per LOAD/SETUP/WRITE round, with idle timeout.
// Optional feature: define BS_LOADER_CHECKSUM_EN to add a count-of-ones check at end of load.
module bs_loader
    import bs_pkg::*;
#(
    parameter int ADDR_WIDTH = BS_ADDR_WIDTH,
    parameter int NUM_BITS   = 1024,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH:0]     in_addr,
    input  logic                    in_bit,
    output logic                    in_ready,
    output logic [ADDR_WIDTH:0]     address,
    output logic                    data_in,
    output logic                    cfg_we,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
`ifdef BS_LOADER_CHECKSUM_EN
    input  logic [BS_CNT_WIDTH-1:0] chk_expected,
    output logic                    chk_ok,
`endif
    output logic [BS_CNT_WIDTH-1:0] bit_cnt
);

    localparam logic [BS_CNT_WIDTH-1:0] LP_NUM_BITS = BS_CNT_WIDTH'(NUM_BITS);

    bs_loader_state_t        r_state;
    logic [ADDR_WIDTH:0]     r_address;
    logic                    r_data_in;
    logic                    r_cfg_we;
    logic                    r_in_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [BS_CNT_WIDTH-1:0] r_bit_cnt;

    logic                    w_handshake;
    logic                    w_start_ok;
    logic                    w_to_clear;
    logic                    w_to_en;
    logic                    w_expired;
    logic [BS_CNT_WIDTH-1:0] w_bit_cnt_nxt;

`ifdef BS_LOADER_CHECKSUM_EN
    logic [BS_CNT_WIDTH-1:0] r_ones;
    logic                    r_chk_ok;
    logic [BS_CNT_WIDTH-1:0] w_ones_nxt;

    assign w_ones_nxt = r_ones + BS_CNT_WIDTH'(r_data_in);
    assign chk_ok     = r_chk_ok;
`endif

    // in_ready is high exactly in LOAD, busy exactly in LOAD/SETUP/WRITE.
    assign w_handshake   = r_in_ready && in_valid;
    assign w_start_ok    = start && !r_busy;
    assign w_bit_cnt_nxt = r_bit_cnt + BS_CNT_WIDTH'(1);
    assign w_to_clear    = w_handshake || w_start_ok;
    assign w_to_en       = (r_state == LOAD) && !w_handshake;

    bs_loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_to_clear),
        .enable  (w_to_en),
        .expired (w_expired)
    );

    // NOTE: every register here is assigned with <= so all next-state terms see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_address  <= '0;
            r_data_in  <= 1'b0;
            r_cfg_we   <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bit_cnt  <= '0;
`ifdef BS_LOADER_CHECKSUM_EN
            r_ones     <= '0;
            r_chk_ok   <= 1'b0;
`endif
        end else begin
            r_cfg_we <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_bit_cnt  <= '0;
`ifdef BS_LOADER_CHECKSUM_EN
                        r_ones     <= '0;
                        r_chk_ok   <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (w_handshake) begin
                        r_address  <= in_addr;
                        r_data_in  <= in_bit;
                        r_in_ready <= 1'b0;
                        r_state    <= SETUP;
                    end else if (w_expired) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_state    <= ERR;
                    end
                end
                SETUP: begin
                    r_cfg_we <= 1'b1;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    r_bit_cnt <= w_bit_cnt_nxt;
`ifdef BS_LOADER_CHECKSUM_EN
                    r_ones    <= w_ones_nxt;
`endif
                    if (w_bit_cnt_nxt == LP_NUM_BITS) begin
                        r_busy <= 1'b0;
`ifdef BS_LOADER_CHECKSUM_EN
                        if (w_ones_nxt == chk_expected) begin
                            r_chk_ok <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_chk_ok <= 1'b0;
                            r_err    <= 1'b1;
                            r_state  <= ERR;
                        end
`else
                        r_done  <= 1'b1;
                        r_state <= DONE;
`endif
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign address  = r_address;
    assign data_in  = r_data_in;
    assign cfg_we   = r_cfg_we;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign bit_cnt  = r_bit_cnt;

endmodule

// File: tb/tb_bs_loader.sv
// Testbench for bs_loader: cycle table for a full load, scoreboard on cfg_we, corner-case sequences.
module tb_bs_loader;

    localparam int AW = 10;

    typedef struct packed {
        logic [AW:0] addr;
        logic        b;
    } entry_t;

    typedef struct {
        logic        start;
        logic        valid;
        logic [AW:0] a;
        logic        b;
        logic [32:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_bit;
    logic [AW:0] in_addr;
    logic        in_ready, data_in, cfg_we, busy, done, err;
    logic [AW:0] address;
    logic [15:0] bit_cnt;
    logic        in_ready_to, data_in_to, cfg_we_to, busy_to, done_to, err_to;
    logic [AW:0] address_to;
    logic [15:0] bit_cnt_to;
    logic [15:0] chk_exp;
    logic        chk_ok, chk_ok_to;

    int n_vec  = 0;
    int n_miss = 0;
    int we_cnt = 0;
    int we_cnt_to = 0;
    entry_t sb[$];
    entry_t ents[4];
    vec_t   tbl[14];

    always #5 clk = ~clk;

    bs_loader #(.ADDR_WIDTH(AW), .NUM_BITS(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_addr(in_addr),
        .in_bit(in_bit), .in_ready(in_ready), .address(address), .data_in(data_in),
        .cfg_we(cfg_we), .busy(busy), .done(done), .err(err),
`ifdef BS_LOADER_CHECKSUM_EN
        .chk_expected(chk_exp), .chk_ok(chk_ok),
`endif
        .bit_cnt(bit_cnt)
    );

    bs_loader #(.ADDR_WIDTH(AW), .NUM_BITS(4), .TIMEOUT(8)) dut_to (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_addr(in_addr),
        .in_bit(in_bit), .in_ready(in_ready_to), .address(address_to), .data_in(data_in_to),
        .cfg_we(cfg_we_to), .busy(busy_to), .done(done_to), .err(err_to),
`ifdef BS_LOADER_CHECKSUM_EN
        .chk_expected(chk_exp), .chk_ok(chk_ok_to),
`endif
        .bit_cnt(bit_cnt_to)
    );

`ifndef BS_LOADER_CHECKSUM_EN
    assign chk_ok    = 1'b0;
    assign chk_ok_to = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] dut_out();
        return {in_ready, cfg_we, busy, done, err, bit_cnt, address, data_in};
    endfunction

    function automatic vec_t mk(input logic s, input logic v, input int a, input logic b,
                                input logic ir, input logic we, input logic bz, input logic dn,
                                input int cnt, input int ea, input logic ed);
        vec_t r;
        r.start = s;
        r.valid = v;
        r.a     = (AW+1)'(a);
        r.b     = b;
        r.exp   = {ir, we, bz, dn, 1'b0, 16'(cnt), (AW+1)'(ea), ed};
        return r;
    endfunction

    // Every write strobe must match the oldest accepted entry.
    always @(negedge clk) begin
        if (cfg_we) begin
            we_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_we", {address, data_in}, '0);
            end else begin
                entry_t e;
                e = sb.pop_front();
                check("we_addr_data", {address, data_in}, {e.addr, e.b});
            end
        end
        if (cfg_we_to) we_cnt_to++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic send(input entry_t e);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1; in_addr = e.addr; in_bit = e.b;
        sb.push_back(e);
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            void'(sb.pop_back());
            check("send_timeout", 64'(ok), 64'd1);
        end
    endtask

    task automatic wait_end();
        for (int i = 0; i < 40 && !(done || err); i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int n0, m;
        ents[0] = '{addr: 3, b: 1'b1};
        ents[1] = '{addr: 5, b: 1'b0};
        ents[2] = '{addr: 7, b: 1'b1};
        ents[3] = '{addr: 9, b: 1'b1};
        //            st v  a  b   ir we bz dn cnt ad d
        tbl[0]  = mk(1, 1, 3, 1,   1, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 3, 1,   0, 0, 1, 0, 0, 3, 1);
        tbl[2]  = mk(0, 1, 5, 0,   0, 1, 1, 0, 0, 3, 1);
        tbl[3]  = mk(0, 1, 5, 0,   1, 0, 1, 0, 1, 3, 1);
        tbl[4]  = mk(0, 1, 5, 0,   0, 0, 1, 0, 1, 5, 0);
        tbl[5]  = mk(0, 1, 7, 1,   0, 1, 1, 0, 1, 5, 0);
        tbl[6]  = mk(0, 1, 7, 1,   1, 0, 1, 0, 2, 5, 0);
        tbl[7]  = mk(0, 1, 7, 1,   0, 0, 1, 0, 2, 7, 1);
        tbl[8]  = mk(0, 1, 9, 1,   0, 1, 1, 0, 2, 7, 1);
        tbl[9]  = mk(0, 1, 9, 1,   1, 0, 1, 0, 3, 7, 1);
        tbl[10] = mk(0, 1, 9, 1,   0, 0, 1, 0, 3, 9, 1);
        tbl[11] = mk(0, 0, 0, 0,   0, 1, 1, 0, 3, 9, 1);
        tbl[12] = mk(0, 0, 0, 0,   0, 0, 0, 1, 4, 9, 1);
        tbl[13] = mk(0, 1, 1, 1,   0, 0, 0, 1, 4, 9, 1);

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_addr = '0; in_bit = 1'b0; chk_exp = 16'd3;
        tick();
        tick();
        check("reset_state", 64'(dut_out()), 64'd0);
        check("reset_state_to", 64'({in_ready_to, cfg_we_to, busy_to, done_to, err_to, bit_cnt_to}), 64'd0);
        rst = 1'b0;

        // Full load, cycle by cycle; start and in_valid arrive together in IDLE.
        n0 = we_cnt;
        for (int i = 0; i < 4; i++) sb.push_back(ents[i]);
        for (int i = 0; i < 14; i++) begin
            start = tbl[i].start; in_valid = tbl[i].valid; in_addr = tbl[i].a; in_bit = tbl[i].b;
            tick();
            check($sformatf("table_row%0d", i), 64'(dut_out()), 64'(tbl[i].exp));
        end
        in_valid = 1'b0;
        check("full_load_we_count", 64'(we_cnt - n0), 64'd4);

        // Timeout: no input after start on the TIMEOUT=8 instance.
        do_reset();
        m = we_cnt_to;
        pulse_start();
        repeat (7) tick();
        check("timeout_8th_load", 64'({err_to, busy_to, in_ready_to}), 64'b011);
        tick();
        check("timeout_9th_load", 64'({err_to, busy_to, in_ready_to, cfg_we_to}), 64'b1000);
        check("timeout_no_we", 64'(we_cnt_to - m), 64'd0);

        // Stall: five idle LOAD cycles mid-load.
        do_reset();
        pulse_start();
        n0 = we_cnt;
        send(ents[0]);
        send(ents[1]);
        tick();
        tick();
        m = we_cnt;
        repeat (5) tick();
        check("stall_no_we", 64'(we_cnt - m), 64'd0);
        check("stall_waiting", 64'({busy, in_ready, bit_cnt}), {46'd0, 2'b11, 16'd2});
        send(ents[2]);
        send(ents[3]);
        wait_end();
        check("stall_done", 64'({done, err, bit_cnt}), {46'd0, 2'b10, 16'd4});
        check("stall_we_count", 64'(we_cnt - n0), 64'd4);

        // Reset in SETUP of bit 2, with start and in_valid also asserted.
        do_reset();
        pulse_start();
        n0 = we_cnt;
        send(ents[0]);
        send(ents[1]);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        sb.delete();
        check("reset_mid_load", 64'(dut_out()), 64'd0);
        repeat (3) tick();
        check("reset_no_we", 64'(we_cnt - n0), 64'd1);
        pulse_start();
        check("restart_from_zero", 64'({busy, in_ready, bit_cnt}), {46'd0, 2'b11, 16'd0});
        for (int i = 0; i < 4; i++) send(ents[i]);
        wait_end();
        check("restart_done", 64'({done, err, bit_cnt}), {46'd0, 2'b10, 16'd4});

        // Start pulse while busy is ignored.
        do_reset();
        pulse_start();
        n0 = we_cnt;
        send(ents[0]);
        send(ents[1]);
        pulse_start();
        check("busy_start_cnt", 64'({busy, bit_cnt}), {47'd0, 1'b1, 16'd1});
        send(ents[2]);
        send(ents[3]);
        wait_end();
        check("busy_start_done", 64'({done, err, bit_cnt}), {46'd0, 2'b10, 16'd4});
        check("busy_start_we", 64'(we_cnt - n0), 64'd4);

`ifdef BS_LOADER_CHECKSUM_EN
        do_reset();
        chk_exp = 16'd3;
        pulse_start();
        for (int i = 0; i < 4; i++) send(ents[i]);
        wait_end();
        check("chk_match", 64'({done, err, chk_ok}), 64'b101);
        chk_exp = 16'd2;
        pulse_start();
        for (int i = 0; i < 4; i++) send(ents[i]);
        wait_end();
        check("chk_mismatch", 64'({done, err, chk_ok}), 64'b010);
        chk_exp = 16'd3;
`endif

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
